// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and bit strobe.
// Back-to-back words shift with no idle bit between them.
module piso_serializer #(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             accept;
   logic             exit_bit;
   logic [WIDTH-1:0] sreg_nxt;

   assign last_bit = ser_en && (cnt == LAST);
   assign in_ready = (state == IDLE) || (state == SHIFT && last_bit);
   assign accept   = in_valid && in_ready;
   assign busy     = (state == SHIFT);

   assign exit_bit = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
   assign sreg_nxt = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]}
                               : {sreg[WIDTH-2:0], 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         ser_out   <= IDLE_LEVEL;
         ser_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               ser_out   <= IDLE_LEVEL;
               ser_valid <= 1'b0;
               done      <= 1'b0;
               if (accept) begin
                  sreg  <= in_data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (ser_en) begin
                  ser_out   <= exit_bit;
                  ser_valid <= 1'b1;
                  if (cnt == LAST) begin
                     done <= 1'b1;
                     // reload on the last bit keeps the link gap-free
                     if (accept) begin
                        sreg <= in_data;
                        cnt  <= '0;
                     end else begin
                        sreg  <= sreg_nxt;
                        cnt   <= '0;
                        state <= IDLE;
                     end
                  end else begin
                     sreg <= sreg_nxt;
                     cnt  <= cnt + CW'(1);
                     done <= 1'b0;
                  end
               end else begin
                  ser_valid <= 1'b0;
                  done      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share
// one stimulus stream; table vectors plus multi-cycle sequences.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       ser_en = 1'b0;
   logic       rdy_m, so_m, sv_m, bz_m, dn_m;
   logic       rdy_l, so_l, sv_l, bz_l, dn_l;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_m (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_m), .ser_en(ser_en), .ser_out(so_m),
      .ser_valid(sv_m), .busy(bz_m), .done(dn_m)
   );

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_l (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_l), .ser_en(ser_en), .ser_out(so_l),
      .ser_valid(sv_l), .busy(bz_l), .done(dn_l)
   );

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic       e;
      logic       crdy;
      logic       rdy;
      logic       som;
      logic       sol;
      logic       sv;
      logic       bz;
      logic       dn;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic v,
                        input logic [7:0] d, input logic e);
      rst      = r;
      in_valid = v;
      in_data  = d;
      ser_en   = e;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] b2b;
   logic [7:0]  w;
   int          nbusy;
   int          ndone;
   int          nsv;

   initial begin
      tick();
      tbl[0]  = '{1'b1,1'b1,8'hB4,1'b1, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b1,8'hB4,1'b1, 1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,8'hB4,1'b1, 1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0};
      tbl[3]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
      tbl[5]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
      tbl[7]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0};
      tbl[8]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
      tbl[10] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0,1'b1};
      tbl[11] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};

      // T1-T3: reset, then one word B4 through both bit orders
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].e);
         if (tbl[i].crdy) begin
            chk($sformatf("v%0d rdy_m", i), rdy_m, tbl[i].rdy);
            chk($sformatf("v%0d rdy_l", i), rdy_l, tbl[i].rdy);
         end
         tick();
         chk($sformatf("v%0d so_m", i), so_m, tbl[i].som);
         chk($sformatf("v%0d so_l", i), so_l, tbl[i].sol);
         chk($sformatf("v%0d sv", i), sv_m, tbl[i].sv);
         chk($sformatf("v%0d sv_l", i), sv_l, tbl[i].sv);
         chk($sformatf("v%0d busy", i), bz_m, tbl[i].bz);
         chk($sformatf("v%0d done", i), dn_m, tbl[i].dn);
      end

      // T4: strobe every third cycle, frame spans 24 busy cycles
      w = 8'hB4;
      nbusy = 0;
      ndone = 0;
      drive(1'b0, 1'b1, w, 1'b0);
      tick();
      if (bz_m) nbusy++;
      chk("t4 acc sv", sv_m, 1'b0);
      for (int k = 0; k < 8; k++) begin
         for (int g = 0; g < 2; g++) begin
            drive(1'b0, 1'b1, 8'h55, 1'b0);
            chk("t4 gap rdy", rdy_m, 1'b0);
            tick();
            if (bz_m) nbusy++;
            if (dn_m) ndone++;
            chk($sformatf("t4 gap%0d sv", k), sv_m, 1'b0);
            chk($sformatf("t4 gap%0d so", k), so_m,
                (k == 0) ? 1'b0 : w[8-k]);
         end
         drive(1'b0, (k == 7) ? 1'b0 : 1'b1, 8'h55, 1'b1);
         tick();
         if (bz_m) nbusy++;
         if (dn_m) ndone++;
         chk($sformatf("t4 bit%0d sv", k), sv_m, 1'b1);
         chk($sformatf("t4 bit%0d so", k), so_m, w[7-k]);
         chk($sformatf("t4 bit%0d so_l", k), so_l, w[k]);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      chk("t4 idle sv", sv_m, 1'b0);
      total++;
      if (nbusy != 24) begin
         bad++;
         $display("FAIL t4 busy cycles act=%0d exp=24", nbusy);
      end
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL t4 done count act=%0d exp=1", ndone);
      end

      // T5: back-to-back B4 then 3C with no gap
      b2b = 16'hB43C;
      ndone = 0;
      nsv = 0;
      drive(1'b0, 1'b1, 8'hB4, 1'b1);
      chk("t5 idle rdy", rdy_m, 1'b1);
      tick();
      chk("t5 acc sv", sv_m, 1'b0);
      chk("t5 acc busy", bz_m, 1'b1);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, (i <= 7) ? 1'b1 : 1'b0, 8'h3C, 1'b1);
         chk($sformatf("t5 b%0d rdy", i), rdy_m, (i == 7) || (i == 15));
         tick();
         if (sv_m) nsv++;
         if (dn_m) ndone++;
         chk($sformatf("t5 b%0d so", i), so_m, b2b[15-i]);
         chk($sformatf("t5 b%0d so_l", i), so_l,
             (i < 8) ? b2b[8+i] : b2b[i-8]);
         chk($sformatf("t5 b%0d done", i), dn_m, (i == 7) || (i == 15));
         chk($sformatf("t5 b%0d busy", i), bz_m, i != 15);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      chk("t5 end sv", sv_m, 1'b0);
      chk("t5 end so", so_m, 1'b0);
      total++;
      if (nsv != 16 || ndone != 2) begin
         bad++;
         $display("FAIL t5 counts sv=%0d done=%0d exp 16/2", nsv, ndone);
      end

      // T6: abort FF after 3 bits, then a clean 81
      drive(1'b0, 1'b1, 8'hFF, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         tick();
         chk($sformatf("t6 ff%0d so", i), so_m, 1'b1);
      end
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      tick();
      chk("t6 rst so", so_m, 1'b0);
      chk("t6 rst sv", sv_m, 1'b0);
      chk("t6 rst busy", bz_m, 1'b0);
      chk("t6 rst done", dn_m, 1'b0);
      nsv = 0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         tick();
         if (sv_m || sv_l) nsv++;
         if (dn_m || dn_l) ndone++;
      end
      total++;
      if (nsv != 0 || ndone != 0) begin
         bad++;
         $display("FAIL t6 after abort sv=%0d done=%0d exp 0/0", nsv, ndone);
      end
      w = 8'h81;
      drive(1'b0, 1'b1, w, 1'b1);
      chk("t6 rdy", rdy_m, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         tick();
         chk($sformatf("t6 81b%0d so", i), so_m, w[7-i]);
         chk($sformatf("t6 81b%0d so_l", i), so_l, w[i]);
         chk($sformatf("t6 81b%0d sv", i), sv_m, 1'b1);
         chk($sformatf("t6 81b%0d done", i), dn_m, i == 7);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      chk("t6 tail so", so_m, 1'b0);
      chk("t6 tail sv", sv_m, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
